// File: rtl/gx4000_asic_ram_ctrl.sv
// gx4000_asic_ram_ctrl
//   16Kx8 ASIC RAM shared between the video fetcher and the CPU, plus the
//   17-byte unlock sequencer that opens the CPU window.
//
// Ports
//   clk_sys, reset            : clock, synchronous active-high reset
//   cpu_addr/cpu_data         : CPU address / write data
//   cpu_wr/cpu_rd             : single-cycle CPU access strobes
//   asic_page_en              : ASIC page mapped at 0x4000-0x7FFF
//   cpu_q/cpu_q_valid         : CPU read data and one-cycle strobe
//   cpu_wait                  : a CPU request is parked behind video
//   vid_addr/vid_rd           : video read request
//   vid_q/vid_q_valid         : video read data and one-cycle strobe
//   asic_unlocked             : unlock sequence accepted
module gx4000_asic_ram_ctrl (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        asic_page_en,
    output logic [7:0]  cpu_q,
    output logic        cpu_q_valid,
    output logic        cpu_wait,
    input  logic [13:0] vid_addr,
    input  logic        vid_rd,
    output logic [7:0]  vid_q,
    output logic        vid_q_valid,
    output logic        asic_unlocked
);

    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  data;
        logic        wr;
    } cpu_req_t;

    logic [7:0]  mem [0:16383];

    cpu_req_t    cur_req;
    cpu_req_t    pend_req;
    cpu_req_t    svc_req;
    logic        pend_vld;
    logic        pend_fill;
    logic        pend_clr;
    logic        svc_en;
    logic        in_win;
    logic        cpu_strobe;

    logic [13:0] ram_addr;
    logic [7:0]  ram_rdata;
    logic [7:0]  ram_wdata;
    logic        ram_we;

    logic        cpu_q_valid_r;
    logic        vid_q_valid_r;
    logic [4:0]  unlock_idx;

    // Sprite pixels and the odd (green) palette bytes are only 4 bits wide.
    function automatic logic [7:0] mask_wdata(input logic [13:0] idx, input logic [7:0] d);
        if ((idx < 14'h1000) || ((idx >= 14'h2400) && (idx <= 14'h243F) && idx[0]))
            return {4'h0, d[3:0]};
        return d;
    endfunction

    function automatic logic [7:0] unlock_byte(input logic [3:0] i);
        case (i)
            4'd0:  return 8'hFF;
            4'd1:  return 8'h00;
            4'd2:  return 8'hFF;
            4'd3:  return 8'h77;
            4'd4:  return 8'hB3;
            4'd5:  return 8'h51;
            4'd6:  return 8'hA8;
            4'd7:  return 8'hD4;
            4'd8:  return 8'h62;
            4'd9:  return 8'h39;
            4'd10: return 8'h9C;
            4'd11: return 8'h46;
            4'd12: return 8'h2B;
            4'd13: return 8'h15;
            4'd14: return 8'h8A;
            default: return 8'hCD;
        endcase
    endfunction

    assign cpu_strobe = cpu_wr | cpu_rd;
    // Window is judged on the state at strobe time; a parked request keeps
    // its right to be served even if the page or lock changes later.
    assign in_win     = asic_unlocked & asic_page_en & (cpu_addr[15:14] == 2'b01);
    assign cur_req    = '{addr: cpu_addr[13:0], data: cpu_data, wr: cpu_wr};

    // Arbitration: video always owns the port; a parked CPU request goes
    // next; a fresh in-window strobe only gets the port when nothing waits.
    always_comb begin
        pend_fill = 1'b0;
        pend_clr  = 1'b0;
        svc_en    = 1'b0;
        svc_req   = cur_req;
        if (vid_rd) begin
            pend_fill = in_win & cpu_strobe & ~pend_vld;
        end else if (pend_vld) begin
            svc_en   = 1'b1;
            svc_req  = pend_req;
            pend_clr = 1'b1;
        end else if (in_win & cpu_strobe) begin
            svc_en = 1'b1;
        end
    end

    assign ram_addr  = vid_rd ? vid_addr : svc_req.addr;
    assign ram_we    = svc_en & svc_req.wr & ~reset;
    assign ram_wdata = mask_wdata(svc_req.addr, svc_req.data);
    assign ram_rdata = mem[ram_addr];

    // RAM contents survive reset.
    always_ff @(posedge clk_sys) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_vld      <= 1'b0;
            pend_req      <= '0;
            cpu_q         <= 8'h00;
            cpu_q_valid_r <= 1'b0;
            vid_q         <= 8'h00;
            vid_q_valid_r <= 1'b0;
        end else begin
            vid_q_valid_r <= vid_rd;
            cpu_q_valid_r <= svc_en & ~svc_req.wr;
            if (vid_rd)
                vid_q <= ram_rdata;
            if (svc_en & ~svc_req.wr)
                cpu_q <= ram_rdata;
            if (pend_fill) begin
                pend_vld <= 1'b1;
                pend_req <= cur_req;
            end else if (pend_clr) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // A reset landing in the cycle a strobe is presented kills it there too.
    assign cpu_q_valid = cpu_q_valid_r & ~reset;
    assign vid_q_valid = vid_q_valid_r & ~reset;
    assign cpu_wait    = pend_vld;

    // Unlock sequencer: 16 table bytes then 0xEE unlocks, anything else at
    // the 17th position relocks. A stray 0xFF restarts at position 1.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            unlock_idx    <= 5'd0;
            asic_unlocked <= 1'b0;
        end else if (cpu_wr && (cpu_addr[15:8] == 8'hBC)) begin
            if (unlock_idx == 5'd16) begin
                asic_unlocked <= (cpu_data == 8'hEE);
                unlock_idx    <= 5'd0;
            end else if (cpu_data == unlock_byte(unlock_idx[3:0])) begin
                unlock_idx <= unlock_idx + 5'd1;
            end else begin
                unlock_idx <= (cpu_data == 8'hFF) ? 5'd1 : 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_gx4000_asic_ram_ctrl.sv
// tb_gx4000_asic_ram_ctrl
//   Directed unlock / window / arbitration scenarios followed by random
//   traffic, all checked every cycle against a transaction-level model.
module tb_gx4000_asic_ram_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_data = '0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        asic_page_en = 1'b0;
    logic [7:0]  cpu_q;
    logic        cpu_q_valid;
    logic        cpu_wait;
    logic [13:0] vid_addr = '0;
    logic        vid_rd = 1'b0;
    logic [7:0]  vid_q;
    logic        vid_q_valid;
    logic        asic_unlocked;

    gx4000_asic_ram_ctrl dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .asic_page_en(asic_page_en),
        .cpu_q(cpu_q), .cpu_q_valid(cpu_q_valid), .cpu_wait(cpu_wait),
        .vid_addr(vid_addr), .vid_rd(vid_rd), .vid_q(vid_q), .vid_q_valid(vid_q_valid),
        .asic_unlocked(asic_unlocked)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
        logic        wr;
    } req_t;

    logic [7:0]  tbl [16] = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4,
                              8'h62, 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD};
    logic [13:0] pool [16] = '{14'h0000, 14'h0010, 14'h0800, 14'h0FFF, 14'h1000, 14'h1234,
                               14'h2000, 14'h23FF, 14'h2400, 14'h2401, 14'h243E, 14'h243F,
                               14'h2440, 14'h2441, 14'h3000, 14'h3FFF};

    // Reference model state
    logic [7:0]  m_mem [16384];
    req_t        pendq [$];
    logic [7:0]  m_cpu_q, m_vid_q;
    logic        m_cpu_v, m_vid_v, m_wait, m_unl, m_q_chk;
    int          m_idx;
    logic        cur_pg = 1'b1;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] stored(input logic [13:0] idx, input logic [7:0] d);
        if (idx < 14'h1000) return d & 8'h0F;
        if (idx >= 14'h2400 && idx <= 14'h243F && idx[0]) return d & 8'h0F;
        return d;
    endfunction

    task automatic serve(input req_t r);
        if (r.wr) m_mem[r.addr] = stored(r.addr, r.data);
        else begin
            m_cpu_q = m_mem[r.addr];
            m_cpu_v = 1'b1;
        end
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input logic rst, input logic [15:0] a, input logic [7:0] d,
                              input logic wr, input logic rd, input logic pg,
                              input logic [13:0] va, input logic vr);
        req_t r;
        logic inwin;
        if (rst) begin
            m_cpu_v = 0; m_vid_v = 0; m_cpu_q = 0; m_vid_q = 0;
            m_wait = 0; m_unl = 0; m_idx = 0; m_q_chk = 1;
            pendq.delete();
            return;
        end
        m_q_chk = 0; m_cpu_v = 0; m_vid_v = 0;
        inwin = m_unl && pg && (a[15:14] == 2'b01);
        r.addr = a[13:0]; r.data = d; r.wr = wr;
        if (vr) begin
            m_vid_q = m_mem[va];
            m_vid_v = 1;
            if (inwin && (wr || rd) && pendq.size() == 0) pendq.push_back(r);
        end else if (pendq.size() != 0) begin
            serve(pendq.pop_front());
        end else if (inwin && (wr || rd)) begin
            serve(r);
        end
        m_wait = (pendq.size() != 0);
        if (wr && a[15:8] == 8'hBC) begin
            if (m_idx == 16) begin
                m_unl = (d == 8'hEE);
                m_idx = 0;
            end else if (d == tbl[m_idx]) m_idx++;
            else m_idx = (d == 8'hFF) ? 1 : 0;
        end
    endtask

    // One clock: drive, check this cycle's outputs, step model, advance.
    task automatic cyc(input logic rst, input logic [15:0] a, input logic [7:0] d,
                       input logic wr, input logic rd, input logic pg,
                       input logic [13:0] va, input logic vr);
        reset = rst; cpu_addr = a; cpu_data = d; cpu_wr = wr; cpu_rd = rd;
        asic_page_en = pg; vid_addr = va; vid_rd = vr;
        #1;
        chk("cpu_q_valid", {7'd0, cpu_q_valid}, {7'd0, m_cpu_v & ~rst});
        chk("vid_q_valid", {7'd0, vid_q_valid}, {7'd0, m_vid_v & ~rst});
        chk("cpu_wait", {7'd0, cpu_wait}, {7'd0, m_wait});
        chk("asic_unlocked", {7'd0, asic_unlocked}, {7'd0, m_unl});
        if ((m_cpu_v && !rst) || m_q_chk) chk("cpu_q", cpu_q, m_cpu_q);
        if ((m_vid_v && !rst) || m_q_chk) chk("vid_q", vid_q, m_vid_q);
        model_step(rst, a, d, wr, rd, pg, va, vr);
        @(posedge clk_sys); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 16'h0000, 8'h00, 0, 0, cur_pg, 14'h0, 0);
    endtask
    task automatic cwr(input logic [15:0] a, input logic [7:0] d);
        cyc(0, a, d, 1, 0, cur_pg, 14'h0, 0);
    endtask
    task automatic crd(input logic [15:0] a);
        cyc(0, a, 8'h00, 0, 1, cur_pg, 14'h0, 0);
    endtask
    task automatic send_seq(input logic [7:0] last);
        for (int i = 0; i < 16; i++) cwr(16'hBC00, tbl[i]);
        cwr(16'hBC00, last);
    endtask

    initial begin
        logic [7:0] prior;
        logic [15:0] ra;
        int op;

        // Reset
        reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        model_step(1, 16'h0, 8'h0, 0, 0, 0, 14'h0, 0);
        chk("rst_cpu_q", cpu_q, 8'h00);
        chk("rst_cpu_q_valid", {7'd0, cpu_q_valid}, 8'h00);
        chk("rst_cpu_wait", {7'd0, cpu_wait}, 8'h00);
        chk("rst_vid_q", vid_q, 8'h00);
        chk("rst_vid_q_valid", {7'd0, vid_q_valid}, 8'h00);
        chk("rst_unlocked", {7'd0, asic_unlocked}, 8'h00);
        idle(2);

        // Unlock, junk writes keep it, then relock with 00 as the 17th byte
        for (int i = 0; i < 16; i++) cwr(16'hBC00, tbl[i]);
        chk("unlock_before_17th", {7'd0, asic_unlocked}, 8'h00);
        cwr(16'hBC00, 8'hEE);
        chk("unlock_after_17th", {7'd0, asic_unlocked}, 8'h01);
        for (int i = 0; i < 17; i++) cwr(16'hBC00, 8'h12);
        chk("junk_keeps_unlock", {7'd0, asic_unlocked}, 8'h01);
        send_seq(8'h00);
        chk("relock_00", {7'd0, asic_unlocked}, 8'h00);

        // Broken run (byte 5 = 00) must not unlock; FF restart then completes
        for (int i = 0; i < 5; i++) cwr(16'hBC00, tbl[i]);
        cwr(16'hBC00, 8'h00);
        for (int i = 5; i < 16; i++) cwr(16'hBC00, tbl[i]);
        cwr(16'hBC00, 8'hEE);
        chk("broken_run_locked", {7'd0, asic_unlocked}, 8'h00);
        for (int i = 0; i < 4; i++) cwr(16'hBC00, tbl[i]);
        cwr(16'hBC00, 8'hFF);
        for (int i = 1; i < 16; i++) cwr(16'hBC00, tbl[i]);
        chk("ff_restart_not_yet", {7'd0, asic_unlocked}, 8'h00);
        cwr(16'hBC00, 8'hEE);
        chk("ff_restart_unlock", {7'd0, asic_unlocked}, 8'h01);

        // Seed every address the rest of the run touches
        for (int i = 0; i < 16; i++) cwr({2'b01, pool[i]}, 8'($urandom));

        // Masking through the CPU window
        cwr(16'h4010, 8'hA5); crd(16'h4010);
        chk("mask_sprite", cpu_q, 8'h05);
        cwr(16'h6401, 8'hA5); crd(16'h6401);
        chk("mask_green", cpu_q, 8'h05);
        cwr(16'h6400, 8'hA5); crd(16'h6400);
        chk("nomask_6400", cpu_q, 8'hA5);

        // Read parked behind three video reads
        cyc(0, 16'h6000, 8'h00, 0, 1, 1, 14'h2400, 1);
        chk("park_wait1", {7'd0, cpu_wait}, 8'h01);
        chk("park_vvalid1", {7'd0, vid_q_valid}, 8'h01);
        cyc(0, 16'h0000, 8'h00, 0, 0, 1, 14'h2401, 1);
        chk("park_wait2", {7'd0, cpu_wait}, 8'h01);
        cyc(0, 16'h0000, 8'h00, 0, 0, 1, 14'h2000, 1);
        chk("park_wait3", {7'd0, cpu_wait}, 8'h01);
        chk("park_noval", {7'd0, cpu_q_valid}, 8'h00);
        idle(1);
        chk("park_served_wait", {7'd0, cpu_wait}, 8'h00);
        chk("park_served_valid", {7'd0, cpu_q_valid}, 8'h01);
        idle(1);

        // Second strobe while parked is dropped; parked entry survives page drop
        cyc(0, 16'h6400, 8'h00, 0, 1, 1, 14'h0010, 1);
        cyc(0, 16'h4010, 8'h77, 1, 0, 1, 14'h0010, 1);
        cyc(0, 16'h0000, 8'h00, 0, 0, 0, 14'h0000, 0);
        chk("page_drop_served", {7'd0, cpu_q_valid}, 8'h01);
        chk("page_drop_data", cpu_q, 8'hA5);
        idle(1);
        cyc(0, 16'h0000, 8'h00, 0, 0, 1, 14'h0010, 1);
        chk("dropped_write", vid_q, 8'h05);

        // Locked window: write ignored, read gives no valid
        send_seq(8'h00);
        prior = m_mem[14'h0000];
        cwr(16'h4000, 8'h55);
        crd(16'h4000);
        chk("locked_no_valid", {7'd0, cpu_q_valid}, 8'h00);
        cyc(0, 16'h0000, 8'h00, 0, 0, 1, 14'h0000, 1);
        chk("locked_ram_kept", vid_q, prior);

        // Reset right after a served read, and reset on a parked read
        send_seq(8'hEE);
        crd(16'h4800);
        cyc(1, 16'h0000, 8'h00, 0, 0, 1, 14'h0, 0);
        idle(1);
        send_seq(8'hEE);
        cyc(0, 16'h6000, 8'h00, 0, 1, 1, 14'h3000, 1);
        cyc(1, 16'h0000, 8'h00, 0, 0, 1, 14'h0, 0);
        chk("rst_pend_cpu_q_valid", {7'd0, cpu_q_valid}, 8'h00);
        chk("rst_pend_cpu_wait", {7'd0, cpu_wait}, 8'h00);
        chk("rst_pend_cpu_q", cpu_q, 8'h00);
        chk("rst_pend_vid_q", vid_q, 8'h00);
        chk("rst_pend_vid_q_valid", {7'd0, vid_q_valid}, 8'h00);
        chk("rst_pend_unlocked", {7'd0, asic_unlocked}, 8'h00);
        idle(3);
        chk("rst_pend_never_valid", {7'd0, cpu_q_valid}, 8'h00);

        // Random traffic, unlocked
        send_seq(8'hEE);
        for (int n = 0; n < 1500; n++) begin
            op = $urandom_range(0, 9);
            ra = {2'b01, pool[$urandom_range(0, 15)]};
            if (op == 7) begin
                ra = 16'($urandom);
                if (ra[15:14] == 2'b01) ra[15] = 1'b1;
            end
            cyc(0, ra, 8'($urandom),
                (op >= 4 && op <= 6) || (op == 7 && $urandom_range(0, 1) == 1),
                (op <= 3),
                ($urandom_range(0, 9) != 0),
                pool[$urandom_range(0, 15)],
                ($urandom_range(0, 2) == 0));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gx4000_asic_ram_ctrl.md
GX4000_ASIC_RAM_CTRL -- requirements
Module: gx4000_asic_ram_ctrl

Interface
REQ-001 SHALL have ports: clk_sys  in  1  system clock; all logic on its rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: cpu_addr  in  16  CPU address; cpu_data  in  8  CPU write data.
REQ-004 SHALL have ports: cpu_wr, cpu_rd  in  1 each  single-cycle access strobes.
REQ-005 SHALL have ports: asic_page_en  in  1  ASIC page mapped at 0x4000-0x7FFF (from RMR2).
REQ-006 SHALL have ports: cpu_q  out  8  read data; cpu_q_valid  out  1  one-cycle read-data strobe; cpu_wait  out  1  CPU access pending.
REQ-007 SHALL have ports: vid_addr  in  14  video read address; vid_rd  in  1  video read request; vid_q  out  8  read data; vid_q_valid  out  1  one-cycle data strobe.
REQ-008 SHALL have ports: asic_unlocked  out  1  unlock sequence accepted.
REQ-009 SHALL have parameter: none.

Function
REQ-010 SHALL contain one single-port 16384x8 RAM; at most one access (read or write) per clk_sys cycle.
REQ-011 Video read: vid_rd=1 in cycle N SHALL give vid_q=RAM[vid_addr] with vid_q_valid=1 in cycle N+1 only; video always wins arbitration.
REQ-012 CPU access is "in window" when asic_unlocked=1, asic_page_en=1, cpu_addr[15:14]=2'b01; RAM index = cpu_addr[13:0].
REQ-013 Out-of-window CPU strobes SHALL not touch the RAM and SHALL not assert cpu_q_valid or cpu_wait.
REQ-014 In-window strobe with vid_rd=0 and no pending request: served same cycle; reads give cpu_q/cpu_q_valid in N+1.
REQ-015 In-window strobe coinciding with vid_rd=1: captured (addr, data, rd/wr) into a 1-entry pending register; cpu_wait=1 from N+1 until the cycle after service.
REQ-016 Pending request SHALL be served in the first cycle with vid_rd=0; a read's cpu_q_valid follows one cycle later.
REQ-017 New CPU strobe while pending register full SHALL be dropped (no RAM access, no valid); pending entry unaffected.
REQ-018 Write masking: index 0x0000-0x0FFF (sprite pixels) stores {4'h0, cpu_data[3:0]}; index 0x2400-0x243F with odd index (palette green) stores {4'h0, cpu_data[3:0]}; all others store cpu_data.
REQ-019 Window/unlock check SHALL use state at strobe time; a pending entry is served even if lock/page state changes before service.
REQ-020 Unlock sequencer: counter idx 0..16 advanced by cpu_wr with cpu_addr[15:8]=8'hBC, using cpu_data.
REQ-021 Table T[0..15] = FF,00,FF,77,B3,51,A8,D4,62,39,9C,46,2B,15,8A,CD.
REQ-022 idx<16: cpu_data=T[idx] -> idx+1; mismatch -> idx=1 if cpu_data=8'hFF else idx=0; asic_unlocked unchanged.
REQ-023 idx=16: cpu_data=8'hEE -> asic_unlocked=1, else asic_unlocked=0; idx=0 either way.
REQ-024 Non-BCxx writes and all reads SHALL not change idx.
REQ-025 A BCxx write with address also in window is impossible (disjoint ranges); no interaction.

Reset
REQ-026 On reset: cpu_q=0, cpu_q_valid=0, cpu_wait=0, vid_q=0, vid_q_valid=0, asic_unlocked=0, idx=0, pending cleared (in-flight request discarded, no valid emitted).
REQ-027 RAM contents SHALL not be cleared by reset.
REQ-028 Reset asserted in the cycle after a read strobe SHALL suppress that read's valid.

Verification
REQ-029 Write 16-byte table then EE to 0xBC00 -> asic_unlocked=1 after the 17th write; then write 8'h12 to BC00 x17 sequence ending 00 -> asic_unlocked=0.
REQ-030 Sequence with byte 5 = 00 then FF,00,FF... restart -> unlock only after full correct 17-byte run.
REQ-031 Unlocked, page_en=1: write 0xA5 to 0x4010, read 0x4010 -> cpu_q=0x05 one cycle later; write 0xA5 to 0x6401 -> reads 0x05; to 0x6400 -> 0xA5.
REQ-032 CPU read 0x6000 same cycle as vid_rd (3 cycles) -> cpu_wait=1 for 3 cycles, cpu_q_valid one cycle after vid_rd drops; vid_q_valid every cycle.
REQ-033 Locked: write 0x55 to 0x4000 -> RAM unchanged (vid read returns prior value), no cpu_q_valid.
REQ-034 Pending read plus reset -> all outputs 0 next cycle, no cpu_q_valid, asic_unlocked=0.
